// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of fetched {instr, pc, pc+4} entries between
// fetch and decode. Stalls fetch when full; drops everything on a redirect.
module fetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ILEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [ILEN-1:0]            enq_instr,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_pc_plus_4,
  output logic                       stall_fetch,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [ILEN-1:0]            deq_instr,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_pc_plus_4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  logic [ILEN-1:0]  instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  pc4_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  logic full;
  logic empty;
  logic enq_fire;
  logic deq_fire;

  // Status decoded from the registered count only (full is never bypassed)
  always_comb begin
    full     = (cnt == CNT_W'(DEPTH));
    empty    = (cnt == '0);
    enq_fire = enq_valid & ~full & ~flush;
    deq_fire = ~empty & deq_ready & ~flush;
  end

  // Pointer and occupancy state; flush outranks enqueue and dequeue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq_fire && !deq_fire)      cnt <= cnt + CNT_W'(1);
      else if (deq_fire && !enq_fire) cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage; contents are left as-is on reset and flush
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      instr_mem[wr_ptr] <= enq_instr;
      pc_mem[wr_ptr]    <= enq_pc;
      pc4_mem[wr_ptr]   <= enq_pc_plus_4;
    end
  end

  // Head presentation; an empty queue shows a NOP at PC 0
  always_comb begin
    stall_fetch   = full;
    deq_valid     = ~empty;
    count         = cnt;
    deq_instr     = NOP;
    deq_pc        = '0;
    deq_pc_plus_4 = '0;
    if (!empty) begin
      deq_instr     = instr_mem[rd_ptr];
      deq_pc        = pc_mem[rd_ptr];
      deq_pc_plus_4 = pc4_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic [31:0] enq_instr;
  logic [31:0] enq_pc;
  logic [31:0] enq_pc_plus_4;
  logic        stall_fetch;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [31:0] deq_pc_plus_4;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t q[$];

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .ILEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .enq_valid     (enq_valid),
    .enq_instr     (enq_instr),
    .enq_pc        (enq_pc),
    .enq_pc_plus_4 (enq_pc_plus_4),
    .stall_fetch   (stall_fetch),
    .deq_ready     (deq_ready),
    .deq_valid     (deq_valid),
    .deq_instr     (deq_instr),
    .deq_pc        (deq_pc),
    .deq_pc_plus_4 (deq_pc_plus_4),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the model's queue contents imply
  task automatic check_model();
    logic [31:0] ei, ep, ep4;
    if (q.size() == 0) begin
      ei = 32'h13; ep = 32'h0; ep4 = 32'h0;
    end else begin
      ei = q[0].instr; ep = q[0].pc; ep4 = q[0].pc4;
    end
    chk("count", 64'(count), 64'(q.size()));
    chk("deq_valid", 64'(deq_valid), 64'(q.size() != 0));
    chk("stall_fetch", 64'(stall_fetch), 64'(q.size() == DEPTH));
    chk("deq_instr", 64'(deq_instr), 64'(ei));
    chk("deq_pc", 64'(deq_pc), 64'(ep));
    chk("deq_pc_plus_4", 64'(deq_pc_plus_4), 64'(ep4));
  endtask

  // One cycle: drive at negedge, check, clock, then advance the model
  task automatic step(input logic f, input logic ev, input logic [31:0] ins,
                      input logic [31:0] pc, input logic dr);
    bit   was_full;
    bit   do_deq;
    ent_t e;
    flush         = f;
    enq_valid     = ev;
    enq_instr     = ins;
    enq_pc        = pc;
    enq_pc_plus_4 = pc + 32'd4;
    deq_ready     = dr;
    check_model();
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      was_full = (q.size() == DEPTH);
      do_deq   = (q.size() != 0) && dr;
      if (do_deq) void'(q.pop_front());
      if (ev && !was_full) begin
        e.instr = ins; e.pc = pc; e.pc4 = pc + 32'd4;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_instr = '0;
    enq_pc = '0; enq_pc_plus_4 = '0; deq_ready = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_instr", 64'(deq_instr), 64'h13);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Reset mid-cycle with three entries queued
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hA000 + 32'(i), 32'h40 + 32'(4*i), 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #3 reset = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(deq_valid), 64'd0);
    chk("mid_rst_instr", 64'(deq_instr), 64'h13);
    chk("mid_rst_stall", 64'(stall_fetch), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Fill and stall
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hB000 + 32'(i), 32'(4*i), 1'b0);
    chk("fill_stall", 64'(stall_fetch), 64'd1);
    chk("fill_count", 64'(count), 64'd4);
    step(1'b0, 1'b1, 32'hB010, 32'h10, 1'b0);
    chk("stall_count", 64'(count), 64'd4);
    chk("stall_pc", 64'(deq_pc), 64'h0);
    chk("stall_pc4", 64'(deq_pc_plus_4), 64'h4);

    // Full plus dequeue: enqueue refused, accepted one cycle later
    step(1'b0, 1'b1, 32'hB010, 32'h10, 1'b1);
    chk("fdq_count", 64'(count), 64'd3);
    chk("fdq_pc", 64'(deq_pc), 64'h4);
    step(1'b0, 1'b1, 32'hB010, 32'h10, 1'b0);
    chk("fdq_refill", 64'(count), 64'd4);

    // Streaming and wrap
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'hC000 + 32'(i), 32'h100 + 32'(4*i), 1'b1);
      chk("stream_pc", 64'(deq_pc), 64'(32'h100 + 32'(4*i)));
      chk("stream_count", 64'(count), 64'd1);
    end

    // Flush priority over enqueue and dequeue
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hD000, 32'h180, 1'b0);
    step(1'b0, 1'b1, 32'hD001, 32'h184, 1'b0);
    step(1'b1, 1'b1, 32'hD200, 32'h200, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(deq_valid), 64'd0);
    chk("flush_stall", 64'(stall_fetch), 64'd0);
    step(1'b0, 1'b1, 32'hD300, 32'h300, 1'b0);
    chk("post_flush_pc", 64'(deq_pc), 64'h300);

    // Empty handshake
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("empty_count", 64'(count), 64'd0);
      chk("empty_valid", 64'(deq_valid), 64'd0);
      chk("empty_instr", 64'(deq_instr), 64'h13);
    end

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom,
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
    end
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
